ddr_line_master: RTL and testbench
==================================

// Module: ddr_line_master
// PURPOSE
//  AXI4-style initiator for the DDR1 SDRAM controller's shared arw/w/b/r user port. Moves one line
//  (1..LINE_WORDS 32-bit words) between a local flop line buffer and SDRAM. Used by cache refill and
//  writeback paths: the client fills or drains the buffer, then issues a single read or write request.
// PARAMETERS
//  ADDR_BITS  27    byte-address width; equals BA_BITS+ROW_BITS+COL_BITS+1 of the controller
//  LINE_WORDS 8     buffer depth in 32-bit words; power of two, 2..256
//  LEN_BITS   3     log2(LINE_WORDS)
//  TIMEOUT    1023  idle cycles without a handshake before hang is raised (10-bit counter)
// PORTS
//  clk        in  1          single clock for all logic
//  reset_n    in  1          asynchronous, active-low reset
//  req_valid  in  1          client request valid
//  req_ready  out 1          high in IDLE only
//  req_write  in  1          1 = buffer->SDRAM, 0 = SDRAM->buffer
//  req_addr   in  ADDR_BITS  byte address; bits [1:0] are forced to 0 on arw_addr
//  req_len    in  LEN_BITS   number of words minus 1
//  req_id     in  1          forwarded to arw_id
//  done       out 1          one-cycle pulse at transfer end
//  err        out 1          valid with done: protocol error seen
//  hang       out 1          sticky; a handshake wait exceeded TIMEOUT
//  buf_we     in  1          client buffer write; honoured only in IDLE
//  buf_waddr  in  LEN_BITS   client write index
//  buf_wdata  in  32         client write data
//  buf_raddr  in  LEN_BITS   client read index
//  buf_rdata  out 32         combinational buf[buf_raddr]
//  arw_valid/arw_ready/arw_addr[ADDR_BITS-1:0]/arw_len[7:0]/arw_write/arw_id  controller address channel
//  wvalid/wready/wlast/wdata[31:0]          controller write channel (wstrb=4'hf, size=3'd2, burst=2'b01)
//  bvalid/bready/bid                        controller write response
//  rvalid/rready/rlast/rdata[31:0]/rid      controller read channel
// BEHAVIOUR
//  Reset (async, reset_n low): state IDLE, idx=0, arw_valid=wvalid=bready=rready=0, done=err=hang=0.
//   req_ready reads 1 but no request is taken while reset_n is low. Buffer contents are not reset.
//   Reset asserted mid-transfer aborts the transfer immediately; the controller needs its own reset.
//  States: IDLE -> ADDR -> (WDATA -> WRESP | RDATA) -> DONE -> IDLE.
//  IDLE: req_ready=1. On req_valid, latch addr/len/write/id, clear idx and err, go to ADDR.
//   buf_we writes buf[buf_waddr] in IDLE only. During a read, the engine's write to the buffer
//   takes precedence.
//  ADDR: arw_valid=1; arw_addr={addr[ADDR_BITS-1:2],2'b00}; arw_len={0,len}; fields held stable until
//   arw_ready. On handshake, go to WDATA if write, else RDATA.
//  WDATA: wvalid=1, wdata=buf[idx] (same cycle), wlast=(idx==len). On wready, increment idx. On wready
//   with wlast, go to WRESP. wdata/wlast are held stable while wready is low.
//  WRESP: bready=1. On bvalid, set err if bid!=id, then go to DONE.
//  RDATA: rready=1 every cycle, because the controller ignores backpressure. On rvalid, write buf[idx]=rdata
//   and increment idx. On rvalid&rlast, go to DONE.
//   err is set if rlast arrives with idx!=len, if rid!=id, or if rvalid arrives after beat len without rlast.
//   idx saturates at len; surplus beats are dropped.
//  DONE: done=1 for exactly 1 cycle, err is valid, then go to IDLE. req_ready=0 in DONE.
//  Timeout: a 10-bit counter runs in ADDR/WDATA/WRESP/RDATA. It clears on any handshake or state change.
//   Reaching TIMEOUT sets hang (sticky until reset). The FSM keeps waiting and never abandons a burst.
//  Latency: req accept -> arw_valid is 1 cycle. Last beat -> done is 1 cycle.
//   Back-to-back: next req_ready comes 2 cycles after the last handshake.
// TESTING
//  1 Fill buf with 0xA0..0xA7; write addr 0x0000104, len 7 -> arw_addr=0x0000104, arw_len=7, arw_write=1;
//    8 beats 0xA0..0xA7; wlast on beat 8 only; bready until bvalid; done=1, err=0.
//  2 Read addr 0x0000104, len 3; controller returns 0xB0..0xB3 with rlast on beat 4 -> buf[0..3]=0xB0..0xB3,
//    buf[4..7] unchanged, rready=1 throughout, done=1, err=0.
//  3 wready toggled 1,0,0,1,... during write of len 3 -> wdata/wlast stable across stalls; exactly 4 beats.
//  4 Read len 3 with rlast on beat 2 -> done 1 cycle later, err=1. Then a rid mismatch on a clean burst -> err=1.
//  5 buf_we pulses and req_valid held during an active read -> buffer is not written by client,
//    no second arw is issued until after done.
//  6 arw_ready held low 1100 cycles -> hang=1 at cycle 1023, arw_valid still 1. Then reset_n low mid-WDATA ->
//    wvalid=0 immediately, hang=0, state IDLE.

Source files
------------

// File: rtl/ddr_line_master.sv
// ddr_line_master: moves one cache line (1..LINE_WORDS 32-bit words) between a
// local flop line buffer and the DDR controller's AXI4-style arw/w/b/r user port.
// The client fills or drains the buffer while idle, then issues one request.
module ddr_line_master #(
  parameter int ADDR_BITS  = 27,
  parameter int LINE_WORDS = 8,
  parameter int LEN_BITS   = 3,
  parameter int TIMEOUT    = 1023
) (
  input  logic                 clk,
  input  logic                 reset_n,
  // client request
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [LEN_BITS-1:0]  req_len,
  input  logic                 req_id,
  output logic                 done,
  output logic                 err,
  output logic                 hang,
  // client buffer access
  input  logic                 buf_we,
  input  logic [LEN_BITS-1:0]  buf_waddr,
  input  logic [31:0]          buf_wdata,
  input  logic [LEN_BITS-1:0]  buf_raddr,
  output logic [31:0]          buf_rdata,
  // controller address channel
  output logic                 arw_valid,
  input  logic                 arw_ready,
  output logic [ADDR_BITS-1:0] arw_addr,
  output logic [7:0]           arw_len,
  output logic                 arw_write,
  output logic                 arw_id,
  // controller write data channel
  output logic                 wvalid,
  input  logic                 wready,
  output logic                 wlast,
  output logic [31:0]          wdata,
  // controller write response channel
  input  logic                 bvalid,
  output logic                 bready,
  input  logic                 bid,
  // controller read data channel
  input  logic                 rvalid,
  output logic                 rready,
  input  logic                 rlast,
  input  logic [31:0]          rdata,
  input  logic                 rid
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WDATA, S_WRESP, S_RDATA, S_DONE
  } state_t;

  // Word-aligned byte address: the two lowest address bits never reach the controller.
  localparam logic [ADDR_BITS-1:0] ADDR_MASK = ~ADDR_BITS'(3);
  localparam logic [9:0]           TMO_MAX   = 10'(TIMEOUT);
  localparam logic [9:0]           TMO_LAST  = 10'(TIMEOUT - 1);

  state_t                state, state_next;
  logic [ADDR_BITS-1:0]  addr_q;
  logic [LEN_BITS-1:0]   len_q;
  logic                  write_q;
  logic                  id_q;
  logic [LEN_BITS-1:0]   idx;
  logic                  beat_len_seen;  // read beat number len already stored
  logic                  err_q;
  logic                  hang_q;
  logic [9:0]            tmo_cnt;
  logic [31:0]           line_buf [LINE_WORDS];

  logic idx_last, busy, any_hs;
  logic arw_hs, w_hs, b_hs, r_hs;
  logic eng_we, mem_we;
  logic [LEN_BITS-1:0] mem_waddr;
  logic [31:0]         mem_wdata;

  assign idx_last = (idx == len_q);
  assign arw_hs   = (state == S_ADDR)  && arw_ready;
  assign w_hs     = (state == S_WDATA) && wready;
  assign b_hs     = (state == S_WRESP) && bvalid;
  assign r_hs     = (state == S_RDATA) && rvalid;
  assign any_hs   = arw_hs || w_hs || b_hs || r_hs;
  assign busy     = (state == S_ADDR) || (state == S_WDATA) ||
                    (state == S_WRESP) || (state == S_RDATA);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Next-state decode: one burst per request, never abandoned once started.
  // NOTE: state_next gets a default before the case so no path infers a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (req_valid) state_next = S_ADDR;
      S_ADDR:  if (arw_ready) state_next = write_q ? S_WDATA : S_RDATA;
      S_WDATA: if (wready && idx_last) state_next = S_WRESP;
      S_WRESP: if (bvalid) state_next = S_DONE;
      S_RDATA: if (rvalid && rlast) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Handshake strobes driven purely from the current state.
  always_comb begin
    req_ready = 1'b0;
    arw_valid = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    rready    = 1'b0;
    done      = 1'b0;
    unique case (state)
      S_IDLE:  req_ready = 1'b1;
      S_ADDR:  arw_valid = 1'b1;
      S_WDATA: wvalid    = 1'b1;
      S_WRESP: bready    = 1'b1;
      S_RDATA: rready    = 1'b1;  // controller ignores backpressure
      S_DONE:  done      = 1'b1;
      default: ;
    endcase
  end

  // Request latch, beat index and protocol error tracking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q        <= '0;
      len_q         <= '0;
      write_q       <= 1'b0;
      id_q          <= 1'b0;
      idx           <= '0;
      beat_len_seen <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            addr_q        <= req_addr & ADDR_MASK;
            len_q         <= req_len;
            write_q       <= req_write;
            id_q          <= req_id;
            idx           <= '0;
            beat_len_seen <= 1'b0;
            err_q         <= 1'b0;
          end
        end
        S_WDATA: begin
          if (wready && !idx_last) idx <= idx + LEN_BITS'(1);
        end
        S_WRESP: begin
          if (bvalid && (bid != id_q)) err_q <= 1'b1;
        end
        S_RDATA: begin
          if (rvalid) begin
            // Beats past len are dropped and flagged; idx stays parked at len.
            if (beat_len_seen)  err_q         <= 1'b1;
            else if (idx_last)  beat_len_seen <= 1'b1;
            else                idx           <= idx + LEN_BITS'(1);
            if (rid != id_q)          err_q <= 1'b1;
            if (rlast && !idx_last)   err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake watchdog: counts stalled cycles, raises a sticky hang flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
      hang_q  <= 1'b0;
    end else if (!busy || any_hs || (state_next != state)) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != TMO_MAX) begin
      tmo_cnt <= tmo_cnt + 10'd1;
      if (tmo_cnt == TMO_LAST) hang_q <= 1'b1;
    end
  end

  // Buffer write port: the read engine owns it during RDATA, the client only in IDLE.
  assign eng_we    = r_hs && !beat_len_seen;
  assign mem_we    = eng_we || ((state == S_IDLE) && buf_we);
  assign mem_waddr = eng_we ? idx   : buf_waddr;
  assign mem_wdata = eng_we ? rdata : buf_wdata;

  // Line buffer storage.
  // NOTE: the buffer array has no reset; its contents survive reset and are
  // always written by the client or the read engine before being used.
  always_ff @(posedge clk) begin
    if (mem_we) line_buf[mem_waddr] <= mem_wdata;
  end

  assign buf_rdata = line_buf[buf_raddr];
  assign wdata     = line_buf[idx];
  assign wlast     = idx_last;
  assign arw_addr  = addr_q;
  assign arw_len   = 8'(len_q);
  assign arw_write = write_q;
  assign arw_id    = id_q;
  assign err       = err_q;
  assign hang      = hang_q;

endmodule

// File: tb/tb_ddr_line_master.sv
// tb_ddr_line_master: drives the client side and plays the DDR controller;
// expected address, write beats and done/err outcomes are queued at issue time
// and popped by an independent monitor when the DUT presents them.
module tb_ddr_line_master;
  localparam int AB = 27;
  localparam int LW = 8;
  localparam int LB = 3;
  localparam logic [AB-1:0] ADDR_MASK = ~AB'(3);

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req_valid, req_ready, req_write, req_id;
  logic [AB-1:0] req_addr;
  logic [LB-1:0] req_len;
  logic          done, err, hang;
  logic          buf_we;
  logic [LB-1:0] buf_waddr, buf_raddr;
  logic [31:0]   buf_wdata, buf_rdata;
  logic          arw_valid, arw_ready, arw_write, arw_id;
  logic [AB-1:0] arw_addr;
  logic [7:0]    arw_len;
  logic          wvalid, wready, wlast;
  logic [31:0]   wdata;
  logic          bvalid, bready, bid;
  logic          rvalid, rready, rlast, rid;
  logic [31:0]   rdata;

  always #5 clk = ~clk;

  ddr_line_master #(.ADDR_BITS(AB), .LINE_WORDS(LW), .LEN_BITS(LB), .TIMEOUT(1023)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_id(req_id),
    .done(done), .err(err), .hang(hang),
    .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
    .buf_raddr(buf_raddr), .buf_rdata(buf_rdata),
    .arw_valid(arw_valid), .arw_ready(arw_ready), .arw_addr(arw_addr),
    .arw_len(arw_len), .arw_write(arw_write), .arw_id(arw_id),
    .wvalid(wvalid), .wready(wready), .wlast(wlast), .wdata(wdata),
    .bvalid(bvalid), .bready(bready), .bid(bid),
    .rvalid(rvalid), .rready(rready), .rlast(rlast), .rdata(rdata), .rid(rid)
  );

  typedef struct { logic [AB-1:0] addr; logic [7:0] len; logic wr; logic id; } arw_t;
  typedef struct { logic [31:0] data; logic last; } w_t;

  arw_t        exp_arw[$];
  w_t          exp_w[$];
  logic        exp_err[$];
  logic [31:0] ref_buf [LW];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: scoreboards every presented handshake and checks stall stability.
  logic          prev_w_stall, prev_a_stall, prev_wlast;
  logic [31:0]   prev_wdata;
  logic [AB-1:0] prev_aaddr;
  logic [7:0]    prev_alen;

  always @(negedge clk) begin : mon
    arw_t ea;
    w_t   ew;
    logic ee;
    if (!reset_n) begin
      prev_w_stall = 1'b0;
      prev_a_stall = 1'b0;
    end else begin
      if (arw_valid && arw_ready) begin
        check("arw_expected", exp_arw.size() != 0, 1);
        if (exp_arw.size() != 0) begin
          ea = exp_arw.pop_front();
          check("arw_addr", arw_addr, ea.addr);
          check("arw_len", arw_len, ea.len);
          check("arw_write", arw_write, ea.wr);
          check("arw_id", arw_id, ea.id);
        end
      end
      if (wvalid && wready) begin
        check("w_expected", exp_w.size() != 0, 1);
        if (exp_w.size() != 0) begin
          ew = exp_w.pop_front();
          check("wdata", wdata, ew.data);
          check("wlast", wlast, ew.last);
        end
      end
      if (done) begin
        check("done_expected", exp_err.size() != 0, 1);
        if (exp_err.size() != 0) begin
          ee = exp_err.pop_front();
          check("err", err, ee);
        end
      end
      if (prev_w_stall && wvalid) begin
        check("wdata_stable", wdata, prev_wdata);
        check("wlast_stable", wlast, prev_wlast);
      end
      if (prev_a_stall && arw_valid) begin
        check("arw_addr_stable", arw_addr, prev_aaddr);
        check("arw_len_stable", arw_len, prev_alen);
      end
      prev_w_stall = wvalid && !wready;
      prev_a_stall = arw_valid && !arw_ready;
      prev_wdata   = wdata;
      prev_wlast   = wlast;
      prev_aaddr   = arw_addr;
      prev_alen    = arw_len;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic buf_write(input int i, input logic [31:0] d);
    buf_we = 1'b1; buf_waddr = LB'(i); buf_wdata = d;
    tick();
    buf_we = 1'b0;
    ref_buf[i] = d;
  endtask

  task automatic check_buffer(input string name);
    for (int i = 0; i < LW; i++) begin
      buf_raddr = LB'(i);
      tick();
      check(name, buf_rdata, ref_buf[i]);
    end
  endtask

  task automatic issue_req(input logic wr, input logic [AB-1:0] addr, input int len, input logic id);
    int n = 0;
    while (!req_ready && n < 50) begin tick(); n++; end
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_len = LB'(len); req_id = id;
    tick();
    req_valid = 1'b0;
    check("arw_latency", arw_valid, 1);
  endtask

  task automatic serve_arw(input int delay);
    arw_ready = 1'b0;
    repeat (delay) tick();
    arw_ready = 1'b1;
    tick();
    arw_ready = 1'b0;
  endtask

  // Finish a transfer whose last handshake happened at the edge just passed.
  task automatic finish_xfer();
    check("done_latency", done, 1);
    req_valid = 1'b0;
    tick();
    check("done_pulse", done, 0);
    check("req_ready_after_done", req_ready, 1);
  endtask

  // wmode: 0 always ready, 1 ready pattern 1,0,0 repeating, 2 random.
  task automatic do_write(input logic [AB-1:0] addr, input int len, input logic id,
                          input logic b_id, input int wmode);
    arw_t ea;
    w_t   ew;
    int   beats = 0, n = 0;
    ea.addr = addr & ADDR_MASK; ea.len = 8'(len); ea.wr = 1'b1; ea.id = id;
    exp_arw.push_back(ea);
    for (int i = 0; i <= len; i++) begin
      ew.data = ref_buf[i]; ew.last = (i == len);
      exp_w.push_back(ew);
    end
    exp_err.push_back(b_id != id);
    issue_req(1'b1, addr, len, id);
    serve_arw($urandom_range(0, 2));
    while (beats <= len && n < 400) begin
      case (wmode)
        0:       wready = 1'b1;
        1:       wready = (n % 3 == 0);
        default: wready = 1'($urandom_range(0, 1));
      endcase
      if (wvalid && wready) beats++;
      tick();
      n++;
    end
    wready = 1'b0;
    check("w_beat_count", beats, len + 1);
    check("wvalid_after_last", wvalid, 0);
    check("bready", bready, 1);
    repeat ($urandom_range(0, 3)) tick();
    bvalid = 1'b1; bid = b_id;
    tick();
    bvalid = 1'b0;
    finish_xfer();
  endtask

  task automatic do_read(input logic [AB-1:0] addr, input int len, input logic id,
                         input logic r_id, input int nbeats, input logic [31:0] base,
                         input bit hold_req, input bit junk);
    arw_t ea;
    ea.addr = addr & ADDR_MASK; ea.len = 8'(len); ea.wr = 1'b0; ea.id = id;
    exp_arw.push_back(ea);
    exp_err.push_back((r_id != id) || (nbeats != len + 1));
    issue_req(1'b0, addr, len, id);
    if (hold_req) req_valid = 1'b1;
    serve_arw($urandom_range(0, 2));
    for (int k = 0; k < nbeats; k++) begin
      repeat ($urandom_range(0, 2)) begin
        if (junk) begin
          buf_we = 1'b1; buf_waddr = LB'($urandom); buf_wdata = 32'hDEAD_0000 | k;
        end
        check("rready_idle_gap", rready, 1);
        if (hold_req) check("req_ready_busy", req_ready, 0);
        tick();
      end
      buf_we = 1'b0;
      rvalid = 1'b1; rdata = base + k; rlast = (k == nbeats - 1); rid = r_id;
      check("rready_beat", rready, 1);
      tick();
      rvalid = 1'b0; rlast = 1'b0;
    end
    for (int k = 0; k < nbeats && k <= len; k++) ref_buf[k] = base + k;
    finish_xfer();
    if (hold_req) begin
      tick();
      check("no_second_arw", arw_valid, 0);
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    logic [AB-1:0] a;
    int            len, r, nb;
    logic          id;
    reset_n = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_addr = '0; req_len = '0; req_id = 1'b0;
    buf_we = 1'b0; buf_waddr = '0; buf_wdata = '0; buf_raddr = '0;
    arw_ready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = 1'b0;
    rvalid = 1'b0; rlast = 1'b0; rdata = '0; rid = 1'b0;
    repeat (3) tick();
    // Reset state; a request held during reset is not taken.
    check("rst_req_ready", req_ready, 1);
    check("rst_arw_valid", arw_valid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_bready", bready, 0);
    check("rst_rready", rready, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_hang", hang, 0);
    req_valid = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    tick();

    // Full-line write of 0xA0..0xA7.
    for (int i = 0; i < LW; i++) buf_write(i, 32'hA0 + i);
    do_write(27'h0000104, 7, 1'b0, 1'b0, 0);
    // Partial read into buf[0..3]; buf[4..7] keeps its data.
    do_read(27'h0000104, 3, 1'b1, 1'b1, 4, 32'hB0, 1'b0, 1'b0);
    check_buffer("buf_after_read");
    // Write with stalls: ready pattern 1,0,0,1,...
    do_write(27'h0000203, 3, 1'b1, 1'b1, 1);
    // Single-word write.
    do_write(27'h7FFFFFF, 0, 1'b0, 1'b0, 0);
    // Early rlast, then rid mismatch, then surplus beats.
    do_read(27'h0000300, 3, 1'b0, 1'b0, 2, 32'hC0, 1'b0, 1'b0);
    do_read(27'h0000400, 3, 1'b0, 1'b1, 4, 32'hD0, 1'b0, 1'b0);
    do_read(27'h0000500, 2, 1'b1, 1'b1, 5, 32'hE0, 1'b0, 1'b0);
    // Write response with mismatched id.
    do_write(27'h0000600, 2, 1'b1, 1'b0, 2);
    check_buffer("buf_after_errs");
    // Client pokes buffer and holds req_valid during an active read.
    do_read(27'h0000700, 7, 1'b0, 1'b0, 8, 32'hF0, 1'b1, 1'b1);
    check_buffer("buf_after_busy_pokes");

    // Randomised transfers.
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 1) == 1)
        repeat ($urandom_range(1, 4)) buf_write($urandom_range(0, LW - 1), $urandom);
      a   = AB'($urandom);
      len = $urandom_range(0, LW - 1);
      id  = 1'($urandom);
      r   = $urandom_range(0, 5);
      if ($urandom_range(0, 1) == 1) begin
        do_write(a, len, id, (r == 0) ? ~id : id, 2);
      end else begin
        nb = (r == 0) ? $urandom_range(1, len + 3) : len + 1;
        do_read(a, len, id, (r == 1) ? ~id : id, nb, $urandom, 1'b0, 1'b0);
      end
      if (t % 10 == 9) check_buffer("buf_random");
    end

    // Address-channel stall: hang after 1023 stalled cycles, arw stays valid.
    begin
      arw_t ea;
      ea.addr = 27'h0000800; ea.len = 8'd3; ea.wr = 1'b1; ea.id = 1'b1;
      exp_arw.push_back(ea);
      issue_req(1'b1, 27'h0000800, 3, 1'b1);
      for (int i = 0; i < 1100; i++) begin
        if (i == 1022) check("hang_before_limit", hang, 0);
        if (i == 1023) check("hang_at_limit", hang, 1);
        tick();
      end
      check("arw_valid_while_hung", arw_valid, 1);
      check("hang_sticky", hang, 1);
      arw_ready = 1'b1;
      tick();
      arw_ready = 1'b0;
      tick();
      check("wvalid_in_wdata", wvalid, 1);
      #2 reset_n = 1'b0;
      #1;
      check("abort_wvalid", wvalid, 0);
      check("abort_hang", hang, 0);
      check("abort_req_ready", req_ready, 1);
      check("abort_arw_valid", arw_valid, 0);
      check("abort_done", done, 0);
      @(negedge clk) reset_n = 1'b1;
      tick();
    end
    check_buffer("buf_survives_reset");

    check("arw_queue_empty", exp_arw.size(), 0);
    check("w_queue_empty", exp_w.size(), 0);
    check("done_queue_empty", exp_err.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
